tester_spi_slave_ctrl: RTL and testbench
========================================

// Module: tester_spi_slave_ctrl
// PURPOSE
//  Tester-side SPI slave sequencer on the board-level SPI link; the DUT is the SPI master.
//  Oversamples SCK/MOSI/SSn in the tester clock domain and shifts received bytes out to the bench.
//  Serves response bytes on MISO from a TX FIFO that the test sequencer fills.
//  Sits between the bench sequencer and the PCB delay model. SPI mode 0, MSB first.
// PARAMETERS
//  DATA_W      8  bits per SPI frame byte
//  TX_DEPTH    4  TX FIFO entries (power of 2, >=2)
//  SYNC_STAGES 2  synchroniser flops on iSCK/iMOSI/iSSn (>=2)
// PORTS
//  iCLK      in   1       tester clock; must run >= 8x SCK frequency
//  iRST      in   1       asynchronous reset, active-high
//  iSCK      in   1       SPI clock from DUT via PCB (asynchronous to iCLK)
//  iMOSI     in   1       SPI data from DUT
//  iSSn      in   1       SPI slave select from DUT, active-low
//  oMISO     out  1       SPI data to DUT
//  iTX_DATA  in   DATA_W  response byte to queue
//  iTX_VALID in   1       iTX_DATA valid
//  oTX_READY out  1       TX FIFO not full
//  oRX_DATA  out  DATA_W  last received byte
//  oRX_VALID out  1       oRX_DATA valid; held until accepted
//  iRX_READY in   1       bench accepts oRX_DATA
//  oBUSY     out  1       frame in progress (synchronised SSn low)
//  oERR      out  3       sticky {abort, underrun, overrun}
//  iCLR_ERR  in   1       clears oERR (takes priority over a same-cycle set)
// BEHAVIOUR
//  Reset: oMISO=1, oTX_READY=1, oRX_DATA=0, oRX_VALID=0, oBUSY=0, oERR=0, FIFO empty, FSM IDLE.
//  Edges are detected on the synchronised signals (last two sync stages). sck_rise samples MOSI.
//  sck_fall shifts MISO. Edge-to-action latency is SYNC_STAGES+1 cycles.
//  FSM states:
//   IDLE:  oMISO=1. On a synchronised SSn falling edge -> LOAD.
//   LOAD:  one cycle. Pop the FIFO into tx_shift; if the FIFO is empty, load IDLE_BYTE and set oERR[1].
//          Drive the MSB on oMISO. bit_cnt=0. -> SHIFT.
//   SHIFT: On sck_rise, rx_shift={rx_shift,MOSI} and bit_cnt++. On sck_fall, shift tx_shift left.
//          When bit_cnt==DATA_W at a falling edge -> LOAD for the next byte (no extra SCK gap is required).
//  Byte completion: on the DATA_W-th sck_rise, rx_shift+bit is delivered to the RX holding register.
//   If oRX_VALID==0: oRX_DATA is updated and oRX_VALID is set the next cycle.
//   If oRX_VALID==1 and iRX_READY==0: the new byte is dropped and oERR[0] is set.
//   If oRX_VALID==1 and iRX_READY==1 in the same cycle: the new byte replaces it, oRX_VALID stays 1, no overrun.
//  SSn rising edge in any state -> IDLE immediately.
//   If bit_cnt is in 1..DATA_W-1, the partial byte is discarded and oERR[2] is set.
//   bit_cnt==0 is not an abort.
//  TX FIFO: push on iTX_VALID&&oTX_READY; oTX_READY=!full; pointers wrap modulo TX_DEPTH.
//   A same-cycle push and pop on an empty FIFO is an underrun: pop sees pre-push state, and the pushed byte stays queued.
//   A same-cycle push and pop on a full FIFO cannot occur (oTX_READY=0).
//  SCK edges while in IDLE are ignored.
//  Reset asserted mid-frame returns all state to the reset values; the FIFO is flushed.
// CONFIGURATION
//  SPI_ECHO_EN defined: on underrun, LOAD transmits the last completed received byte (0 after reset).
//   oERR[1] is still set.
//  SPI_ECHO_EN undefined: on underrun, LOAD transmits IDLE_BYTE (all ones).
// STRUCTURE
//  Package tester_spi_pkg holds:
//   DATA_W default, IDLE_BYTE = {DATA_W{1'b1}}, state enum {IDLE,LOAD,SHIFT}, and ERR_* bit indices.
//  Sub-module tester_spi_txfifo: synchronous FIFO with push/pop/full/empty, parameterised DATA_W and TX_DEPTH.
//  Synchroniser, edge detect, FSM and RX holding register live in the top module.
// TESTING (iCLK 100 MHz, SCK 10 MHz through pcb_delay, mode 0)
//  Push A5,3C; DUT sends 2-byte frame MOSI 81,7E -> MISO A5,3C; RX 81 then 7E (bench ready=1); oERR=0.
//  Empty FIFO, 1-byte frame MOSI 55 -> MISO FF (or, with SPI_ECHO_EN, the previous RX byte); oERR=3'b010.
//  iRX_READY=0, frame MOSI 11,22 -> oRX_DATA=11 held, oERR=3'b001; iCLR_ERR -> oERR=0.
//  SSn deasserted after 3 SCK rises -> no oRX_VALID, oERR=3'b100, FSM IDLE, oMISO=1.
//  Push 5 bytes with TX_DEPTH=4 -> oTX_READY low after 4 pushes; the 5th is held off until the first pop.
//  iRST asserted mid-byte -> all outputs at reset values in the same cycle; next frame with FIFO empty gives underrun.

Source files
------------

// File: rtl/tester_spi_pkg.sv
// Shared constants and types for the tester-side SPI slave sequencer.
package tester_spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam logic [SPI_DATA_W-1:0] IDLE_BYTE = '1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_e;

  localparam int ERR_OVERRUN  = 0;
  localparam int ERR_UNDERRUN = 1;
  localparam int ERR_ABORT    = 2;
  localparam int ERR_W        = 3;

endpackage

// File: rtl/tester_spi_txfifo.sv
// Response-byte FIFO feeding MISO; push/pop are gated by full/empty.
module tester_spi_txfifo
  import tester_spi_pkg::*;
#(
  parameter int DATA_W   = SPI_DATA_W,
  parameter int TX_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(TX_DEPTH);

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [DATA_W-1:0] mem_q [TX_DEPTH];
  logic              do_push;
  logic              do_pop;

  // Extra pointer bit tells full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + (AW+1)'(1);
    if (do_pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tester_spi_slave_ctrl.sv
// Tester-side SPI slave (mode 0, MSB first) with TX FIFO and RX holding register.
// Define SPI_ECHO_EN to echo the last received byte on TX underrun.
module tester_spi_slave_ctrl
  import tester_spi_pkg::*;
#(
  parameter int DATA_W      = SPI_DATA_W,
  parameter int TX_DEPTH    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSCK,
  input  logic              iMOSI,
  input  logic              iSSn,
  output logic              oMISO,
  input  logic [DATA_W-1:0] iTX_DATA,
  input  logic              iTX_VALID,
  output logic              oTX_READY,
  output logic [DATA_W-1:0] oRX_DATA,
  output logic              oRX_VALID,
  input  logic              iRX_READY,
  output logic              oBUSY,
  output logic [ERR_W-1:0]  oERR,
  input  logic              iCLR_ERR
);

  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_W);
  localparam logic [DATA_W-1:0] FILL = {DATA_W{IDLE_BYTE[0]}};

  // One stage beyond the synchroniser gives the previous value for edge detect.
  logic [SYNC_STAGES:0]   sck_sync_q;
  logic [SYNC_STAGES:0]   ssn_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  logic sck_rise, sck_fall;
  logic ssn_rise, ssn_fall;
  logic mosi_s;

  state_e            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-2:0] rx_shift_q, rx_shift_d;
  logic              miso_q, miso_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              busy_q, busy_d;

  logic [DATA_W-1:0] rx_byte;
  logic [DATA_W-1:0] load_byte;
  logic [DATA_W-1:0] under_byte;
  logic [ERR_W-1:0]  fsm_err;
  logic              rx_done;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;

  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_sync_q[SYNC_STAGES];
  assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_sync_q[SYNC_STAGES];
  assign ssn_rise = ssn_sync_q[SYNC_STAGES-1] & ~ssn_sync_q[SYNC_STAGES];
  assign ssn_fall = ~ssn_sync_q[SYNC_STAGES-1] & ssn_sync_q[SYNC_STAGES];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rx_byte  = {rx_shift_q, mosi_s};

`ifdef SPI_ECHO_EN
  logic [DATA_W-1:0] last_rx_q, last_rx_d;

  always_comb begin
    last_rx_d = last_rx_q;
    if (rx_done) last_rx_d = rx_byte;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) last_rx_q <= '0;
    else      last_rx_q <= last_rx_d;
  end

  assign under_byte = last_rx_q;
`else
  assign under_byte = FILL;
`endif

  tester_spi_txfifo #(
    .DATA_W   (DATA_W),
    .TX_DEPTH (TX_DEPTH)
  ) u_txfifo (
    .clk   (iCLK),
    .rst   (iRST),
    .push  (iTX_VALID),
    .wdata (iTX_DATA),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    miso_d     = miso_q;
    load_byte  = fifo_empty ? under_byte : fifo_rdata;
    fifo_pop   = 1'b0;
    rx_done    = 1'b0;
    fsm_err    = '0;
    unique case (state_q)
      IDLE: begin
        miso_d = 1'b1;
        if (ssn_fall) state_d = LOAD;
      end
      LOAD: begin
        fifo_pop   = 1'b1;
        fsm_err[ERR_UNDERRUN] = fifo_empty;
        tx_shift_d = load_byte;
        miso_d     = load_byte[DATA_W-1];
        bit_cnt_d  = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (sck_rise && bit_cnt_q != CNT_LAST) begin
          rx_shift_d = rx_byte[DATA_W-2:0];
          bit_cnt_d  = bit_cnt_q + CW'(1);
          rx_done    = (bit_cnt_q == CNT_LAST - CW'(1));
        end else if (sck_fall) begin
          if (bit_cnt_q == CNT_LAST) begin
            state_d = LOAD;
          end else begin
            tx_shift_d = tx_shift_q << 1;
            miso_d     = tx_shift_q[DATA_W-2];
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Deselect wins over everything, including a same-cycle final SCK fall.
    if (ssn_rise) begin
      state_d   = IDLE;
      miso_d    = 1'b1;
      bit_cnt_d = '0;
      fifo_pop  = 1'b0;
      rx_done   = 1'b0;
      fsm_err   = '0;
      fsm_err[ERR_ABORT] = (state_q == SHIFT) &&
                           (bit_cnt_q != '0) &&
                           (bit_cnt_q != CNT_LAST);
    end
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    err_d      = err_q | fsm_err;
    busy_d     = ~ssn_sync_q[SYNC_STAGES-1];
    if (rx_valid_q && iRX_READY) rx_valid_d = 1'b0;
    if (rx_done) begin
      if (!rx_valid_q || iRX_READY) begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end else begin
        err_d[ERR_OVERRUN] = 1'b1;
      end
    end
    if (iCLR_ERR) err_d = '0;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sck_sync_q  <= '0;
      ssn_sync_q  <= '1;
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      miso_q      <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-1:0], iSCK};
      ssn_sync_q  <= {ssn_sync_q[SYNC_STAGES-1:0], iSSn};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], iMOSI};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      miso_q      <= miso_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign oMISO     = miso_q;
  assign oTX_READY = ~fifo_full;
  assign oRX_DATA  = rx_data_q;
  assign oRX_VALID = rx_valid_q;
  assign oBUSY     = busy_q;
  assign oERR      = err_q;

endmodule

// File: tb/tb_tester_spi_slave_ctrl.sv
// Bench for tester_spi_slave_ctrl: SPI master driver and queue-based reference model.
// Build with SPI_ECHO_EN defined to check the echo-on-underrun variant.
module tb_tester_spi_slave_ctrl;

  logic       iCLK = 1'b0;
  logic       iRST = 1'b1;
  logic       iSCK = 1'b0;
  logic       iMOSI = 1'b0;
  logic       iSSn = 1'b1;
  logic       oMISO;
  logic [7:0] iTX_DATA = 8'h00;
  logic       iTX_VALID = 1'b0;
  logic       oTX_READY;
  logic [7:0] oRX_DATA;
  logic       oRX_VALID;
  logic       iRX_READY = 1'b1;
  logic       oBUSY;
  logic [2:0] oERR;
  logic       iCLR_ERR = 1'b0;

  tester_spi_slave_ctrl dut (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iSCK      (iSCK),
    .iMOSI     (iMOSI),
    .iSSn      (iSSn),
    .oMISO     (oMISO),
    .iTX_DATA  (iTX_DATA),
    .iTX_VALID (iTX_VALID),
    .oTX_READY (oTX_READY),
    .oRX_DATA  (oRX_DATA),
    .oRX_VALID (oRX_VALID),
    .iRX_READY (iRX_READY),
    .oBUSY     (oBUSY),
    .oERR      (oERR),
    .iCLR_ERR  (iCLR_ERR)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_rx[$];
  logic [7:0] rx_seen[$];
  logic [7:0] mo_buf[8];
  logic [7:0] mi_buf[8];
  logic [2:0] m_err = 3'b000;
  logic [7:0] m_last = 8'h00;
  logic [7:0] m_hold = 8'h00;
  logic       m_hold_v = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  always @(negedge iCLK)
    if (!iRST && oRX_VALID && iRX_READY) rx_seen.push_back(oRX_DATA);

  function automatic logic [7:0] m_under();
`ifdef SPI_ECHO_EN
    return m_last;
`else
    return 8'hFF;
`endif
  endfunction

  task automatic push(input logic [7:0] b);
    chk("tx_ready", 32'(oTX_READY), 32'(tx_q.size() < 4));
    iTX_DATA  = b;
    iTX_VALID = 1'b1;
    @(posedge iCLK);
    #2;
    iTX_VALID = 1'b0;
    if (tx_q.size() < 4) tx_q.push_back(b);
  endtask

  // Mode 0 master: MOSI changes with SCK low, MISO sampled at the rise.
  // Deselect coincides with the last SCK fall.
  task automatic spi_xfer(input int nbits);
    iSSn = 1'b0;
    #100;
    for (int j = 0; j < nbits; j++) begin
      iMOSI = mo_buf[j/8][7-j%8];
      #50;
      iSCK = 1'b1;
      mi_buf[j/8][7-j%8] = oMISO;
      if (j == 0) chk("busy", 32'(oBUSY), 32'(1));
      #50;
      iSCK = 1'b0;
    end
    iSSn  = 1'b1;
    iMOSI = 1'b0;
    #200;
  endtask

  task automatic cmp_rx();
    chk("rx_count", 32'(rx_seen.size()), 32'(exp_rx.size()));
    while (rx_seen.size() != 0 && exp_rx.size() != 0)
      chk("rx_byte", 32'(rx_seen.pop_front()), 32'(exp_rx.pop_front()));
    rx_seen.delete();
    exp_rx.delete();
  endtask

  task automatic check_frame(input int n);
    logic [7:0] e;
    for (int b = 0; b < n; b++) begin
      if (tx_q.size() != 0) begin
        e = tx_q.pop_front();
      end else begin
        e = m_under();
        m_err[1] = 1'b1;
      end
      chk("miso_byte", 32'(mi_buf[b]), 32'(e));
      m_last = mo_buf[b];
      if (iRX_READY) exp_rx.push_back(mo_buf[b]);
      else if (!m_hold_v) begin
        m_hold   = mo_buf[b];
        m_hold_v = 1'b1;
      end else m_err[0] = 1'b1;
    end
    cmp_rx();
    chk("err", 32'(oERR), 32'(m_err));
    chk("miso_idle", 32'(oMISO), 32'(1));
    chk("busy_idle", 32'(oBUSY), 32'(0));
  endtask

  task automatic clr_err();
    iCLR_ERR = 1'b1;
    @(posedge iCLK);
    #2;
    iCLR_ERR = 1'b0;
    m_err = 3'b000;
    chk("err_clr", 32'(oERR), 32'(0));
  endtask

  task automatic chk_reset_vals();
    chk("rst_miso", 32'(oMISO), 32'(1));
    chk("rst_txrdy", 32'(oTX_READY), 32'(1));
    chk("rst_rxdata", 32'(oRX_DATA), 32'(0));
    chk("rst_rxvalid", 32'(oRX_VALID), 32'(0));
    chk("rst_busy", 32'(oBUSY), 32'(0));
    chk("rst_err", 32'(oERR), 32'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] e;
    logic [7:0] b5;
    int got;
    int np;
    int nb;

    repeat (3) @(posedge iCLK);
    #2;
    chk_reset_vals();
    iRST = 1'b0;
    #100;

    push(8'hA5);
    push(8'h3C);
    mo_buf[0] = 8'h81;
    mo_buf[1] = 8'h7E;
    spi_xfer(16);
    check_frame(2);

    mo_buf[0] = 8'h55;
    spi_xfer(8);
    check_frame(1);
    clr_err();

    iRX_READY = 1'b0;
    push(8'h01);
    push(8'h02);
    mo_buf[0] = 8'h11;
    mo_buf[1] = 8'h22;
    spi_xfer(16);
    check_frame(2);
    chk("rx_hold_data", 32'(oRX_DATA), 32'(m_hold));
    chk("rx_hold_valid", 32'(oRX_VALID), 32'(m_hold_v));
    clr_err();
    iRX_READY = 1'b1;
    exp_rx.push_back(m_hold);
    m_hold_v = 1'b0;
    repeat (3) @(posedge iCLK);
    #2;
    cmp_rx();
    chk("rx_drained", 32'(oRX_VALID), 32'(0));

    push(8'h99);
    mo_buf[0] = 8'($urandom);
    spi_xfer(3);
    e = tx_q.pop_front();
    m_err[2] = 1'b1;
    chk("abort_miso", 32'(mi_buf[0][7:5]), 32'(e[7:5]));
    cmp_rx();
    chk("abort_rxvalid", 32'(oRX_VALID), 32'(0));
    chk("abort_err", 32'(oERR), 32'(m_err));
    chk("abort_miso_idle", 32'(oMISO), 32'(1));
    chk("abort_busy", 32'(oBUSY), 32'(0));

    for (int k = 0; k < 4; k++) push(8'($urandom));
    iSSn = 1'b0;
    #100;
    for (int j = 0; j < 3; j++) begin
      iMOSI = 1'($urandom);
      #50;
      iSCK = 1'b1;
      #50;
      iSCK = 1'b0;
    end
    iMOSI = 1'($urandom);
    #50;
    iSCK = 1'b1;
    #20;
    iRST = 1'b1;
    #1;
    chk_reset_vals();
    #9;
    iSCK  = 1'b0;
    iSSn  = 1'b1;
    iMOSI = 1'b0;
    tx_q.delete();
    m_err    = 3'b000;
    m_last   = 8'h00;
    m_hold_v = 1'b0;
    #50;
    iRST = 1'b0;
    #100;
    rx_seen.delete();
    mo_buf[0] = 8'($urandom);
    spi_xfer(8);
    check_frame(1);
    clr_err();

    for (int k = 0; k < 4; k++) push(8'($urandom));
    chk("tx_full", 32'(oTX_READY), 32'(0));
    b5 = 8'($urandom);
    mo_buf[0] = 8'($urandom);
    got = 0;
    fork
      spi_xfer(8);
      begin
        iTX_DATA  = b5;
        iTX_VALID = 1'b1;
        for (int c = 0; c < 300 && got == 0; c++) begin
          if (oTX_READY) got = 1;
          @(posedge iCLK);
          #2;
        end
        iTX_VALID = 1'b0;
      end
    join
    chk("push5_accepted", 32'(got), 32'(1));
    if (got != 0) tx_q.push_back(b5);
    check_frame(1);
    for (int b = 0; b < 4; b++) mo_buf[b] = 8'($urandom);
    spi_xfer(32);
    check_frame(4);
    if (m_err != 3'b000) clr_err();

    for (int it = 0; it < 12; it++) begin
      np = $urandom_range(0, 4);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < np && tx_q.size() < 4; k++)
        push(8'($urandom));
      for (int b = 0; b < nb; b++) mo_buf[b] = 8'($urandom);
      spi_xfer(8 * nb);
      check_frame(nb);
      if (m_err != 3'b000) clr_err();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
